alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 Port: clock  in  1  single system clock, rising-edge active.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Ports: req0_valid/req1_valid  in  1  requester N presents an operation.
REQ-005 Ports: req0_ready/req1_ready  out  1  arbiter accepts requester N this cycle.
REQ-006 Ports: req0_in1/req1_in1, req0_in2/req1_in2  in  WIDTH  operands; req0_sel/req1_sel  in  4  ALU opcode.
REQ-007 Ports: rsp0_valid/rsp1_valid  out  1  result for requester N available.
REQ-008 Ports: rsp0_ready/rsp1_ready  in  1  requester N takes its result.
REQ-009 Ports: rsp0_data/rsp1_data  out  WIDTH  result; rsp0_err/rsp1_err  out  1  illegal opcode flag.
REQ-010 Ports: alu_in1, alu_in2  out  WIDTH, alu_sel  out  4  drive shared ALU; alu_out  in  WIDTH  ALU result.
REQ-011 Port: busy  out  1  high whenever state is not IDLE.

Function
REQ-012 FSM states SHALL be IDLE, EXEC, RESP; encoding is internal.
REQ-013 In IDLE, reqN_ready SHALL be high only for the granted requester N, combinationally from valid inputs and grant pointer; both ready low in EXEC/RESP.
REQ-014 Accept (reqN_valid && reqN_ready) SHALL register in1, in2, sel and owner id, then move to EXEC.
REQ-015 In EXEC, alu_in1/alu_in2/alu_sel SHALL be driven from the registered operands; alu_out captured into the result register at the clock edge ending EXEC; move to RESP.
REQ-016 Outside EXEC, alu_in1/alu_in2/alu_sel SHALL be driven to 0.
REQ-017 In RESP, rspN_valid SHALL be high for the owner only, with rspN_data/rspN_err stable until rspN_ready; on rspN_ready move to IDLE.
REQ-018 Latency: accept at edge t gives rspN_valid high from cycle t+2; minimum 3 cycles per operation.
REQ-019 Legal opcodes 4'b0000..4'b1000 (add, sub, and, xor, sra, sll, srl, bne, lui); any other sel SHALL complete normally with rspN_data=0 and rspN_err=1.
REQ-020 A requester deasserting reqN_valid before accept SHALL be ignored; no state change.
REQ-021 Only one operation SHALL be in flight; new requests wait until IDLE.
REQ-022 Grant pointer SHALL update only on accept, to favour the other requester next.

Reset
REQ-023 Reset SHALL force IDLE, grant pointer to requester 0, all registered operands/results to 0, all ready/valid/err and busy to 0, alu_* outputs to 0.
REQ-024 Reset during EXEC or RESP SHALL abandon the in-flight operation with no response issued.

Configuration
REQ-025 Macro ALU_ARB_RR_EN defined: round-robin grant; on simultaneous valid, requester not served last wins.
REQ-026 ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins simultaneous requests; pointer logic absent.

Structure
REQ-027 Shared package alu_pkg SHALL hold the 4-bit opcode constants, ALU_SEL_MAX (4'b1000) and FSM state constants.
REQ-028 The shared resource ALU SHALL be instantiated outside alu_arbiter; optional sub-module alu_arb_grant computes grant/ready.

Verification
REQ-029 req0: in1=12, in2=5, sel=0000 -> rsp0_valid at t+2, rsp0_data=17, rsp0_err=0.
REQ-030 Both valid same cycle, req0 sel=0001, req1 sel=0101, in1=12, in2=5, RR_EN defined, pointer at 0 -> req0 served first (7), then req1 (384); RR_EN undefined with req0 held valid -> req0 repeatedly served, req1 starves.
REQ-031 rsp1_ready held low 5 cycles after rsp1_valid -> rsp1_data stable, busy=1, req0_ready=0 throughout.
REQ-032 sel=1111 -> rspN_data=0, rspN_err=1, FSM returns to IDLE.
REQ-033 reset asserted mid-EXEC -> immediate IDLE, busy=0, no rsp_valid pulse after release.
REQ-034 req0 sel=1000, in1=12, in2=5 -> rsp0_data equals ALU lui result 20480.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU arbiter and the external shared ALU:
//   - 4-bit ALU opcode constants and ALU_SEL_MAX (highest legal opcode)
//   - arbiter FSM state type
//   - sel_is_legal(): opcode legality helper
// Configuration macro used by the arbiter files: ALU_ARB_RR_EN.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SRA = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_BNE = 4'b0111;
    localparam logic [3:0] ALU_LUI = 4'b1000;

    localparam logic [3:0] ALU_SEL_MAX = ALU_LUI;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    function automatic logic sel_is_legal(input logic [3:0] sel);
        return (sel <= ALU_SEL_MAX);
    endfunction

endpackage

// File: rtl/alu_arb_grant.sv
// -----------------------------------------------------------------------------
// alu_arb_grant
// Combinational grant logic for the two-requester ALU arbiter.
// A requester is only offered ready while the arbiter is idle and that
// requester is valid; at most one ready is ever high.
//
// Configuration: ALU_ARB_RR_EN
//   defined   : round-robin, i_ptr names the requester favoured on a tie
//   undefined : fixed priority, requester 0 wins every tie (no pointer port)
//
// Ports:
//   i_idle            arbiter is in IDLE and not in reset
//   i_valid0/i_valid1 requester valid inputs
//   i_ptr             favoured requester on a tie (round-robin build only)
//   o_ready0/o_ready1 ready to the requesters
// -----------------------------------------------------------------------------
module alu_arb_grant (
    input  logic i_idle,
    input  logic i_valid0,
    input  logic i_valid1,
`ifdef ALU_ARB_RR_EN
    input  logic i_ptr,
`endif
    output logic o_ready0,
    output logic o_ready1
);

`ifdef ALU_ARB_RR_EN
    always_comb begin
        o_ready0 = 1'b0;
        o_ready1 = 1'b0;
        if (i_idle) begin
            if (i_valid0 && i_valid1) begin
                o_ready0 = ~i_ptr;
                o_ready1 = i_ptr;
            end else begin
                o_ready0 = i_valid0;
                o_ready1 = i_valid1;
            end
        end
    end
`else
    always_comb begin
        o_ready0 = i_idle & i_valid0;
        o_ready1 = i_idle & i_valid1 & ~i_valid0;
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Arbitrates two requesters onto one shared, externally instantiated ALU.
// One operation is in flight at a time: IDLE -> EXEC -> RESP -> IDLE.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. reqN_ready is combinational and only offered in IDLE.
// rspN_valid stays high with stable data/err until rspN_ready is seen.
//
// Configuration: ALU_ARB_RR_EN (round-robin when defined, else fixed
// priority to requester 0).
//
// Ports:
//   clock, reset              rising-edge clock, async active-high reset
//   reqN_valid/ready          request handshake, N = 0/1
//   reqN_in1/in2/sel          operands and opcode
//   rspN_valid/ready          response handshake
//   rspN_data/err             result and illegal-opcode flag
//   alu_in1/in2/sel, alu_out  shared ALU connection (driven only in EXEC)
//   busy                      high whenever the FSM is not IDLE
//   dbg_state                 current FSM state for observation
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_in1,
    input  logic [WIDTH-1:0] req0_in2,
    input  logic [3:0]       req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_in1,
    input  logic [WIDTH-1:0] req1_in2,
    input  logic [3:0]       req1_sel,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             rsp1_err,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    arb_state_t       r_state;
    logic [WIDTH-1:0] r_in1;
    logic [WIDTH-1:0] r_in2;
    logic [3:0]       r_sel;
    logic             r_owner;
    logic [WIDTH-1:0] r_result;
    logic [1:0]       r_rsp_valid;
    logic [1:0]       r_rsp_err;
    logic             r_busy;
`ifdef ALU_ARB_RR_EN
    logic             r_ptr;
`endif

    logic w_idle;
    logic w_ready0;
    logic w_ready1;
    logic w_acc0;
    logic w_acc1;
    logic w_rsp_take;
    logic w_sel_legal;

    // Ready is held low while reset is asserted even though the state is IDLE.
    assign w_idle = (r_state == ST_IDLE) && !reset;

    alu_arb_grant u_grant (
        .i_idle   (w_idle),
        .i_valid0 (req0_valid),
        .i_valid1 (req1_valid),
`ifdef ALU_ARB_RR_EN
        .i_ptr    (r_ptr),
`endif
        .o_ready0 (w_ready0),
        .o_ready1 (w_ready1)
    );

    assign w_acc0      = req0_valid & w_ready0;
    assign w_acc1      = req1_valid & w_ready1;
    assign w_rsp_take  = r_owner ? rsp1_ready : rsp0_ready;
    assign w_sel_legal = sel_is_legal(r_sel);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_in1       <= '0;
            r_in2       <= '0;
            r_sel       <= '0;
            r_owner     <= 1'b0;
            r_result    <= '0;
            r_rsp_valid <= 2'b00;
            r_rsp_err   <= 2'b00;
            r_busy      <= 1'b0;
`ifdef ALU_ARB_RR_EN
            r_ptr       <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_acc0 || w_acc1) begin
                        r_in1   <= w_acc1 ? req1_in1 : req0_in1;
                        r_in2   <= w_acc1 ? req1_in2 : req0_in2;
                        r_sel   <= w_acc1 ? req1_sel : req0_sel;
                        r_owner <= w_acc1;
                        r_busy  <= 1'b1;
                        r_state <= ST_EXEC;
`ifdef ALU_ARB_RR_EN
                        // Favour the requester that was not just served.
                        r_ptr   <= ~w_acc1;
`endif
                    end
                end
                ST_EXEC: begin
                    // Illegal opcodes still take the normal path but report 0.
                    r_result    <= w_sel_legal ? alu_out : '0;
                    r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
                    r_rsp_err   <= w_sel_legal ? 2'b00 : (r_owner ? 2'b10 : 2'b01);
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_rsp_take) begin
                        r_rsp_valid <= 2'b00;
                        r_rsp_err   <= 2'b00;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 2'b00;
                    r_rsp_err   <= 2'b00;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req0_ready = w_ready0;
    assign req1_ready = w_ready1;

    assign rsp0_valid = r_rsp_valid[0];
    assign rsp1_valid = r_rsp_valid[1];
    assign rsp0_err   = r_rsp_err[0];
    assign rsp1_err   = r_rsp_err[1];
    assign rsp0_data  = r_result;
    assign rsp1_data  = r_result;

    // The shared ALU only sees operands while this arbiter is executing.
    assign alu_in1 = (r_state == ST_EXEC) ? r_in1 : '0;
    assign alu_in2 = (r_state == ST_EXEC) ? r_in2 : '0;
    assign alu_sel = (r_state == ST_EXEC) ? r_sel : 4'b0000;

    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic [3:0]   req0_sel, req1_sel;
  logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [W-1:0] rsp0_data, rsp1_data;
  logic         rsp0_err, rsp1_err;
  logic [W-1:0] alu_in1, alu_in2, alu_out;
  logic [3:0]   alu_sel;
  logic         busy;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // clock / reset block
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // external shared ALU; illegal opcodes return a poison value
  always_comb begin
    case (alu_sel)
      4'b0000: alu_out = alu_in1 + alu_in2;
      4'b0001: alu_out = alu_in1 - alu_in2;
      4'b0010: alu_out = alu_in1 & alu_in2;
      4'b0011: alu_out = alu_in1 ^ alu_in2;
      4'b0100: alu_out = W'($signed(alu_in1) >>> alu_in2[4:0]);
      4'b0101: alu_out = alu_in1 << alu_in2[4:0];
      4'b0110: alu_out = alu_in1 >> alu_in2[4:0];
      4'b0111: alu_out = {{(W-1){1'b0}}, (alu_in1 != alu_in2)};
      4'b1000: alu_out = alu_in2 << 12;
      default: alu_out = 32'hDEAD_BEEF;
    endcase
  end

  alu_arbiter #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_in1   (req0_in1),
    .req0_in2   (req0_in2),
    .req0_sel   (req0_sel),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_in1   (req1_in1),
    .req1_in2   (req1_in2),
    .req1_sel   (req1_sel),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_data  (rsp0_data),
    .rsp0_err   (rsp0_err),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_data  (rsp1_data),
    .rsp1_err   (rsp1_err),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_sel    (alu_sel),
    .alu_out    (alu_out),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // scoreboard compare
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int id);
    return (id == 0) ? req0_ready : req1_ready;
  endfunction

  function automatic logic rsp_v(input int id);
    return (id == 0) ? rsp0_valid : rsp1_valid;
  endfunction

  function automatic logic [W-1:0] rsp_d(input int id);
    return (id == 0) ? rsp0_data : rsp1_data;
  endfunction

  function automatic logic rsp_e(input int id);
    return (id == 0) ? rsp0_err : rsp1_err;
  endfunction

  // driver tasks
  task automatic set_req(input int id, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [3:0] s);
    if (id == 0) begin
      req0_valid = v; req0_in1 = a; req0_in2 = b; req0_sel = s;
    end else begin
      req1_valid = v; req1_in1 = a; req1_in2 = b; req1_sel = s;
    end
  endtask

  task automatic set_valid(input int id, input logic v);
    if (id == 0) req0_valid = v;
    else         req1_valid = v;
  endtask

  task automatic set_rsp_ready(input int id, input logic v);
    if (id == 0) rsp0_ready = v;
    else         rsp1_ready = v;
  endtask

  // Called at a negedge with requester id already presenting; expects it to be
  // granted, runs EXEC/RESP, holds the response 'hold' extra cycles, then acks.
  task automatic serve(input int id, input logic keep_valid, input logic other_valid,
                       input int hold, input logic exp_e);
    logic [W-1:0] exp_d;
    int oth;
    oth = 1 - id;
    exp_d = '0;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      exp_d = exp_q.pop_front();
    end
    #1;
    check($sformatf("grant_ready%0d", id), W'(rdy(id)), 1);
    check($sformatf("grant_other_ready%0d", oth), W'(rdy(oth)), 0);
    @(posedge clock);
    @(negedge clock);
    if (!keep_valid) set_valid(id, 1'b0);
    set_valid(oth, other_valid);
    #1;
    check("exec_busy", W'(busy), 1);
    check("exec_state", W'(dbg_state), 1);
    check("exec_ready0", W'(req0_ready), 0);
    check("exec_ready1", W'(req1_ready), 0);
    check("exec_no_rsp", W'(rsp_v(id)), 0);
    @(negedge clock);
    check($sformatf("rsp%0d_valid", id), W'(rsp_v(id)), 1);
    check($sformatf("rsp%0d_quiet", oth), W'(rsp_v(oth)), 0);
    check($sformatf("rsp%0d_data", id), rsp_d(id), exp_d);
    check($sformatf("rsp%0d_err", id), W'(rsp_e(id)), W'(exp_e));
    check("resp_alu_sel_zero", W'(alu_sel), 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check("hold_valid", W'(rsp_v(id)), 1);
      check("hold_data", rsp_d(id), exp_d);
      check("hold_busy", W'(busy), 1);
      check("hold_ready0", W'(req0_ready), 0);
      check("hold_ready1", W'(req1_ready), 0);
    end
    set_rsp_ready(id, 1'b1);
    @(negedge clock);
    set_rsp_ready(id, 1'b0);
    #1;
    check("ack_valid_low", W'(rsp_v(id)), 0);
    check("ack_busy_low", W'(busy), 0);
    check("ack_state_idle", W'(dbg_state), 0);
  endtask

  initial begin
    reset = 1'b1;
    set_req(0, 1'b0, '0, '0, 4'b0000);
    set_req(1, 1'b0, '0, '0, 4'b0000);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    repeat (2) @(negedge clock);

    // reset state
    check("rst_busy", W'(busy), 0);
    check("rst_state", W'(dbg_state), 0);
    check("rst_ready0", W'(req0_ready), 0);
    check("rst_ready1", W'(req1_ready), 0);
    check("rst_rsp0_valid", W'(rsp0_valid), 0);
    check("rst_rsp1_valid", W'(rsp1_valid), 0);
    check("rst_rsp_err", W'({rsp1_err, rsp0_err}), 0);
    check("rst_alu_in1", alu_in1, 0);
    check("rst_alu_sel", W'(alu_sel), 0);
    reset = 1'b0;
    @(negedge clock);

    // add 12+5
    set_req(0, 1'b1, 12, 5, 4'b0000);
    exp_q.push_back(17);
    serve(0, 1'b0, 1'b0, 0, 1'b0);

    // ALU operands visible only during EXEC
    set_req(1, 1'b1, 32'h0000_00F0, 32'h0000_0FF0, 4'b0011);
    #1;
    @(posedge clock);
    @(negedge clock);
    set_valid(1, 1'b0);
    check("exec_alu_in1", alu_in1, 32'h0000_00F0);
    check("exec_alu_in2", alu_in2, 32'h0000_0FF0);
    check("exec_alu_sel", W'(alu_sel), 3);
    @(negedge clock);
    check("xor_data", rsp1_data, 32'h0000_0F00);
    rsp1_ready = 1'b1;
    @(negedge clock);
    rsp1_ready = 1'b0;

    // both valid in the same cycle
    set_req(0, 1'b1, 12, 5, 4'b0001);
    set_req(1, 1'b1, 12, 5, 4'b0101);
`ifdef ALU_ARB_RR_EN
    // pointer was moved to 0 by the last (req1) accept
    exp_q.push_back(7);
    serve(0, 1'b0, 1'b1, 0, 1'b0);
    set_valid(0, 1'b1);
    exp_q.push_back(384);
    serve(1, 1'b0, 1'b1, 5, 1'b0);
    exp_q.push_back(7);
    serve(0, 1'b0, 1'b0, 0, 1'b0);
`else
    exp_q.push_back(7);
    serve(0, 1'b1, 1'b1, 0, 1'b0);
    exp_q.push_back(7);
    serve(0, 1'b1, 1'b1, 0, 1'b0);
    exp_q.push_back(7);
    serve(0, 1'b0, 1'b1, 0, 1'b0);
    exp_q.push_back(384);
    serve(1, 1'b0, 1'b1, 5, 1'b0);
    set_valid(0, 1'b0);
`endif
    set_valid(0, 1'b0);
    set_valid(1, 1'b0);
    @(negedge clock);

    // illegal opcode
    set_req(0, 1'b1, 12, 5, 4'b1111);
    exp_q.push_back(0);
    serve(0, 1'b0, 1'b0, 0, 1'b1);

    // lui
    set_req(0, 1'b1, 12, 5, 4'b1000);
    exp_q.push_back(20480);
    serve(0, 1'b0, 1'b0, 0, 1'b0);

    // sra on a negative operand, requester 1
    set_req(1, 1'b1, 32'hFFFF_FF00, 4, 4'b0100);
    exp_q.push_back(32'hFFFF_FFF0);
    serve(1, 1'b0, 1'b0, 0, 1'b0);

    // reset in the middle of EXEC
    set_req(0, 1'b1, 12, 5, 4'b0000);
    #1;
    check("pre_rst_ready0", W'(req0_ready), 1);
    @(posedge clock);
    @(negedge clock);
    set_valid(0, 1'b0);
    check("mid_exec_state", W'(dbg_state), 1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", W'(busy), 0);
    check("mid_rst_state", W'(dbg_state), 0);
    check("mid_rst_alu_in1", alu_in1, 0);
    check("mid_rst_alu_sel", W'(alu_sel), 0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("post_rst_rsp0", W'(rsp0_valid), 0);
      check("post_rst_rsp1", W'(rsp1_valid), 0);
      check("post_rst_busy", W'(busy), 0);
    end

    // normal operation after the abandoned one
    set_req(0, 1'b1, 100, 1, 4'b0111);
    exp_q.push_back(1);
    serve(0, 1'b0, 1'b0, 0, 1'b0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
